rv_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage RV32I pipeline, successor to the combinational forwarding/stall unit. Generalises forwarding to NUM_RS source operands, gates x0, adds branch-redirect flushing and variable-latency data-memory freezing via a wait FSM with a timeout watchdog, and provides optional performance counters. It sits beside the pipeline registers and drives their stall/flush enables and the EX/ID operand-select muxes.

---
 rtl/rv_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding, load-use and
// data-memory-wait stalls, redirect flushes. Perf counters exist only with RV_HAZ_PERF_CNT_EN.
module rv_hazard_ctrl #(
   parameter int NUM_RS  = 2,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [5*NUM_RS-1:0]   i_haz_rf_ra_id,
   input  logic [5*NUM_RS-1:0]   i_haz_rf_ra_ex,
   input  logic [4:0]            i_haz_rf_wa_mem,
   input  logic                  i_haz_rf_we_mem,
   input  logic                  i_haz_is_load_mem,
   input  logic [4:0]            i_haz_rf_wa_wb,
   input  logic                  i_haz_rf_we_wb,
   input  logic                  i_haz_br_taken_ex,
   input  logic                  i_haz_dmem_req_mem,
   input  logic                  i_haz_dmem_ack,
   output logic [2*NUM_RS-1:0]   o_haz_rf_rd_sel_ex,
   output logic [NUM_RS-1:0]     o_haz_rf_rd_sel_id,
   output logic                  o_haz_stall_if,
   output logic                  o_haz_stall_id,
   output logic                  o_haz_stall_ex,
   output logic                  o_haz_stall_mem,
   output logic                  o_haz_bubble_mem,
   output logic                  o_haz_bubble_wb,
   output logic                  o_haz_flush_id,
   output logic                  o_haz_flush_ex,
   output logic [1:0]            o_haz_state,
   output logic                  o_haz_dmem_timeout,
   output logic [CNT_W-1:0]      o_haz_cnt_load_use,
   output logic [CNT_W-1:0]      o_haz_cnt_mem_wait,
   output logic [CNT_W-1:0]      o_haz_cnt_flush
);

   localparam logic [1:0] SRC_RF_RD_EX  = 2'd0;
   localparam logic [1:0] SRC_RF_RD_MEM = 2'd1;
   localparam logic [1:0] SRC_RF_RD_WB  = 2'd2;

   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;

   logic [2*NUM_RS-1:0] sel_ex;
   logic [NUM_RS-1:0]   sel_id;
   logic                ex_hits_mem_dest;
   logic                load_use;
   logic                mem_req_stall;
   logic                mem_freeze;
   logic                do_flush;

   always_comb begin
      sel_ex           = '0;
      sel_id           = '0;
      ex_hits_mem_dest = 1'b0;
      for (int k = 0; k < NUM_RS; k++) begin
         if (i_haz_rf_ra_ex[5*k +: 5] != 5'd0 && i_haz_rf_we_mem &&
             i_haz_rf_wa_mem == i_haz_rf_ra_ex[5*k +: 5] && !i_haz_is_load_mem)
            sel_ex[2*k +: 2] = SRC_RF_RD_MEM;
         else if (i_haz_rf_ra_ex[5*k +: 5] != 5'd0 && i_haz_rf_we_wb &&
                  i_haz_rf_wa_wb == i_haz_rf_ra_ex[5*k +: 5])
            sel_ex[2*k +: 2] = SRC_RF_RD_WB;
         else
            sel_ex[2*k +: 2] = SRC_RF_RD_EX;
         if (i_haz_rf_wa_mem != 5'd0 && i_haz_rf_wa_mem == i_haz_rf_ra_ex[5*k +: 5])
            ex_hits_mem_dest = 1'b1;
         sel_id[k] = (i_haz_rf_ra_id[5*k +: 5] != 5'd0) && i_haz_rf_we_wb &&
                     (i_haz_rf_wa_wb == i_haz_rf_ra_id[5*k +: 5]);
      end
   end

   assign load_use      = i_haz_is_load_mem && i_haz_rf_we_mem && ex_hits_mem_dest;
   assign mem_req_stall = i_haz_dmem_req_mem && !i_haz_dmem_ack;
   assign mem_freeze    = mem_req_stall || (state_q == ST_ERR);
   // A redirect under a stall is dropped here; the branch holds in EX and flushes once unstalled.
   assign do_flush      = !i_rst && !mem_freeze && !load_use && i_haz_br_taken_ex;

   always_comb begin
      o_haz_stall_if   = 1'b0;
      o_haz_stall_id   = 1'b0;
      o_haz_stall_ex   = 1'b0;
      o_haz_stall_mem  = 1'b0;
      o_haz_bubble_mem = 1'b0;
      o_haz_bubble_wb  = 1'b0;
      o_haz_flush_id   = 1'b0;
      o_haz_flush_ex   = 1'b0;
      if (!i_rst) begin
         if (mem_freeze) begin
            o_haz_stall_if  = 1'b1;
            o_haz_stall_id  = 1'b1;
            o_haz_stall_ex  = 1'b1;
            o_haz_stall_mem = 1'b1;
            o_haz_bubble_wb = 1'b1;
         end else if (load_use) begin
            o_haz_stall_if   = 1'b1;
            o_haz_stall_id   = 1'b1;
            o_haz_stall_ex   = 1'b1;
            o_haz_bubble_mem = 1'b1;
         end else if (i_haz_br_taken_ex) begin
            o_haz_flush_id = 1'b1;
            o_haz_flush_ex = 1'b1;
         end
      end
   end

   assign o_haz_rf_rd_sel_ex = i_rst ? '0 : sel_ex;
   assign o_haz_rf_rd_sel_id = i_rst ? '0 : sel_id;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_req_stall) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (i_haz_dmem_ack)
               state_d = ST_RUN;
            else if (wait_cnt_q == WCNT_LAST)
               state_d = ST_ERR;
            else
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign o_haz_state        = state_q;
   assign o_haz_dmem_timeout = (state_q == ST_ERR);

`ifdef RV_HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_lu_q, cnt_mw_q, cnt_fl_q;

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_lu_q <= '0;
         cnt_mw_q <= '0;
         cnt_fl_q <= '0;
      end else begin
         if (load_use && !mem_freeze && cnt_lu_q != '1) cnt_lu_q <= cnt_lu_q + CNT_W'(1);
         if (mem_req_stall && cnt_mw_q != '1)           cnt_mw_q <= cnt_mw_q + CNT_W'(1);
         if (do_flush && cnt_fl_q != '1)                cnt_fl_q <= cnt_fl_q + CNT_W'(1);
      end
   end

   assign o_haz_cnt_load_use = cnt_lu_q;
   assign o_haz_cnt_mem_wait = cnt_mw_q;
   assign o_haz_cnt_flush    = cnt_fl_q;
`else
   assign o_haz_cnt_load_use = '0;
   assign o_haz_cnt_mem_wait = '0;
   assign o_haz_cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: a rule-level model is compared every cycle,
// and hand-computed literals pin key points of each scenario.
module tb_rv_hazard_ctrl;
   localparam int NRS = 2;
   localparam int TO  = 4;
   localparam int CW  = 32;
`ifdef RV_HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [5*NRS-1:0]  ra_id, ra_ex;
   logic [4:0]        wa_mem, wa_wb;
   logic              we_mem, is_load, we_wb, br, req, ack;
   logic [2*NRS-1:0]  sel_ex;
   logic [NRS-1:0]    sel_id;
   logic              st_if, st_id, st_ex, st_mem, bub_mem, bub_wb, fl_id, fl_ex;
   logic [1:0]        state;
   logic              tmo;
   logic [CW-1:0]     cnt_lu, cnt_mw, cnt_fl;

   rv_hazard_ctrl #(.NUM_RS(NRS), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_haz_rf_ra_id(ra_id), .i_haz_rf_ra_ex(ra_ex),
      .i_haz_rf_wa_mem(wa_mem), .i_haz_rf_we_mem(we_mem), .i_haz_is_load_mem(is_load),
      .i_haz_rf_wa_wb(wa_wb), .i_haz_rf_we_wb(we_wb),
      .i_haz_br_taken_ex(br), .i_haz_dmem_req_mem(req), .i_haz_dmem_ack(ack),
      .o_haz_rf_rd_sel_ex(sel_ex), .o_haz_rf_rd_sel_id(sel_id),
      .o_haz_stall_if(st_if), .o_haz_stall_id(st_id), .o_haz_stall_ex(st_ex), .o_haz_stall_mem(st_mem),
      .o_haz_bubble_mem(bub_mem), .o_haz_bubble_wb(bub_wb),
      .o_haz_flush_id(fl_id), .o_haz_flush_ex(fl_ex),
      .o_haz_state(state), .o_haz_dmem_timeout(tmo),
      .o_haz_cnt_load_use(cnt_lu), .o_haz_cnt_mem_wait(cnt_mw), .o_haz_cnt_flush(cnt_fl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model state: 0 run, 1 waiting on memory, 2 error; m_waited counts unacked wait cycles.
   int m_state = 0, m_waited = 0;
   int m_lu = 0, m_mw = 0, m_fl = 0;

   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      if (r != 0 && we_mem && wa_mem == r && !is_load) return 2'd1;
      if (r != 0 && we_wb && wa_wb == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit m_load_use();
      bit hit = 0;
      for (int k = 0; k < NRS; k++) if (ra_ex[5*k +: 5] == wa_mem) hit = 1;
      return is_load && we_mem && (wa_mem != 0) && hit;
   endfunction

   always @(posedge clk) begin : model_upd
      bit fz, lu, rs;
      rs = req && !ack;
      fz = rs || (m_state == 2);
      lu = m_load_use();
      if (rst) begin
         m_state <= 0; m_waited <= 0; m_lu <= 0; m_mw <= 0; m_fl <= 0;
      end else begin
         if (lu && !fz) m_lu <= m_lu + 1;
         if (rs)        m_mw <= m_mw + 1;
         if (br && !fz && !lu) m_fl <= m_fl + 1;
         if (m_state == 0 && rs) begin
            m_state <= 1; m_waited <= 0;
         end else if (m_state == 1 && ack) begin
            m_state <= 0;
         end else if (m_state == 1) begin
            if (m_waited + 1 == TO) m_state <= 2;
            m_waited <= m_waited + 1;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit fz, lu;
      logic [2*NRS-1:0] e_sel;
      logic [NRS-1:0]   e_id;
      fz = (req && !ack) || (m_state == 2);
      lu = m_load_use();
      e_sel = '0;
      e_id  = '0;
      for (int k = 0; k < NRS; k++) begin
         e_sel[2*k +: 2] = m_fwd(ra_ex[5*k +: 5]);
         e_id[k] = (ra_id[5*k +: 5] != 0) && we_wb && (wa_wb == ra_id[5*k +: 5]);
      end
      if (rst) begin
         e_sel = '0; e_id = '0; fz = 0; lu = 0;
      end
      chk("m_sel_ex", 64'(sel_ex), 64'(e_sel));
      chk("m_sel_id", 64'(sel_id), 64'(e_id));
      chk("m_stall", {st_if, st_id, st_ex, st_mem}, {fz || lu, fz || lu, fz || lu, fz});
      chk("m_bubble", {bub_mem, bub_wb}, {!fz && lu, fz});
      chk("m_flush", {fl_id, fl_ex}, {2{!rst && !fz && !lu && br}});
      chk("m_state", 64'(state), 64'(m_state));
      chk("m_timeout", 64'(tmo), 64'(m_state == 2));
      chk("m_cnt_lu", 64'(cnt_lu), PERF ? 64'(m_lu) : 64'd0);
      chk("m_cnt_mw", 64'(cnt_mw), PERF ? 64'(m_mw) : 64'd0);
      chk("m_cnt_fl", 64'(cnt_fl), PERF ? 64'(m_fl) : 64'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ra_id = '0; ra_ex = '0; wa_mem = '0; wa_wb = '0;
      we_mem = 0; is_load = 0; we_wb = 0; br = 0; req = 0; ack = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      req = 1; br = 1; we_mem = 1; wa_mem = 5'd5; ra_ex = {5'd0, 5'd5};
      @(negedge clk);
      chk("rst_stall_if", 64'(st_if), 0);
      chk("rst_sel_ex", 64'(sel_ex), 0);
      chk("rst_flush_id", 64'(fl_id), 0);
      tick(); rst = 1'b0; idle();
      @(negedge clk);
      chk("rst_state", 64'(state), 0);
      chk("rst_timeout", 64'(tmo), 0);
      chk("rst_cnt_lu", 64'(cnt_lu), 0);

      // Forwarding: MEM beats WB, both operands
      tick(); ra_ex = {5'd5, 5'd5}; wa_mem = 5'd5; we_mem = 1; wa_wb = 5'd5; we_wb = 1;
      @(negedge clk);
      chk("fwd_mem", 64'(sel_ex), 64'b0101);
      tick(); we_mem = 0;
      @(negedge clk);
      chk("fwd_wb", 64'(sel_ex), 64'b1010);

      // x0 never forwards or stalls; ID bypass
      tick(); idle(); ra_ex = {5'd0, 5'd3}; wa_mem = 5'd0; we_mem = 1; is_load = 1;
      ra_id = {5'd4, 5'd9}; wa_wb = 5'd9; we_wb = 1;
      @(negedge clk);
      chk("x0_sel_ex", 64'(sel_ex), 0);
      chk("x0_stall", 64'(st_if), 0);
      chk("id_bypass", 64'(sel_id), 64'b01);

      // Load-use with coincident redirect, then WB forward and delayed flush
      tick(); idle(); wa_mem = 5'd7; we_mem = 1; is_load = 1; ra_ex = {5'd0, 5'd7}; br = 1;
      @(negedge clk);
      chk("lu_stalls", {st_if, st_id, st_ex, st_mem}, 4'b1110);
      chk("lu_bubble_mem", 64'(bub_mem), 1);
      chk("lu_no_flush", {fl_id, fl_ex}, 2'b00);
      tick(); idle(); wa_wb = 5'd7; we_wb = 1; ra_ex = {5'd0, 5'd7}; br = 1;
      @(negedge clk);
      chk("lu_next_sel", 64'(sel_ex), 64'b0010);
      chk("lu_next_stall", 64'(st_if), 0);
      chk("br_flush", {fl_id, fl_ex}, 2'b11);
      tick(); idle();
      @(negedge clk);
      chk("cnt_lu_1", 64'(cnt_lu), PERF ? 64'd1 : 64'd0);
      chk("cnt_fl_1", 64'(cnt_fl), PERF ? 64'd1 : 64'd0);

      // Memory wait: three unacked cycles then ack
      tick(); req = 1;
      @(negedge clk);
      chk("mw1_state", 64'(state), 0);
      chk("mw1_stalls", {st_if, st_id, st_ex, st_mem, bub_wb}, 5'b11111);
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         chk("mw_state", 64'(state), 1);
         chk("mw_stall_mem", 64'(st_mem), 1);
      end
      tick(); ack = 1;
      @(negedge clk);
      chk("mw_ack_state", 64'(state), 1);
      chk("mw_ack_stall", 64'(st_mem), 0);
      tick(); idle();
      @(negedge clk);
      chk("mw_back_run", 64'(state), 0);
      chk("cnt_mw_3", 64'(cnt_mw), PERF ? 64'd3 : 64'd0);

      // Watchdog: request never acked
      tick(); req = 1;
      for (int i = 0; i < TO; i++) begin
         tick();
         @(negedge clk);
         chk("wd_wait_state", 64'(state), 1);
      end
      tick();
      @(negedge clk);
      chk("wd_err_state", 64'(state), 2);
      chk("wd_timeout", 64'(tmo), 1);
      chk("wd_stall", 64'(st_if), 1);
      tick(); req = 0;
      @(negedge clk);
      chk("err_holds_stall", {st_mem, bub_wb}, 2'b11);
      tick(); rst = 1;
      @(negedge clk);
      chk("err_rst_stall", 64'(st_if), 0);
      tick(); rst = 0;
      @(negedge clk);
      chk("err_rst_state", 64'(state), 0);
      chk("err_rst_timeout", 64'(tmo), 0);

      tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
